// File: rtl/addsub_acc_pkg.sv
// Shared opcodes and sizing helpers for the add/sub/accumulate unit.
package addsub_acc_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;

    // Channel-select width: at least one bit even for a single channel.
    function automatic int chw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract with carry/borrow and optional clamp.
module addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             sat,
    output logic [WIDTH:0]   raw,
    output logic [WIDTH-1:0] clamped,
    output logic             ovf
);

    // Raw sum/difference over WIDTH+1 bits; clamp to rail on carry/borrow when sat.
    always_comb begin
        raw     = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        ovf     = raw[WIDTH];
        clamped = raw[WIDTH-1:0];
        if (sat && raw[WIDTH])
            clamped = sub ? '0 : '1;
    end

endmodule

// File: rtl/addsub_acc_multi.sv
// Registered add/sub/accumulate unit with NCH accumulators and valid/ready I/O.
module addsub_acc_multi
    import addsub_acc_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int NCH      = 2,
    parameter  int SATURATE = 0,
    localparam int CHW      = chw(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [CHW-1:0]   ch,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             zero,
    output logic             ovf
);

    logic [NCH-1:0][WIDTH-1:0] acc;
    logic [WIDTH-1:0]          acc_sel;
    logic                      ch_ok;
    logic                      is_acc;
    logic                      accept;
    logic [WIDTH-1:0]          x, y;
    logic [WIDTH:0]            raw;
    logic [WIDTH-1:0]          clamped;
    logic                      core_ovf;
    logic [WIDTH:0]            res_nxt;
    logic                      ovf_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_acc   = op[1];

    // Select the addressed accumulator; out-of-range channels read as invalid.
    always_comb begin
        acc_sel = '0;
        ch_ok   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ch == CHW'(i)) begin
                acc_sel = acc[i];
                ch_ok   = 1'b1;
            end
        end
    end

    // Operand muxing into the shared core; a same-cycle clear makes the op act on 0.
    always_comb begin
        x = is_acc ? (clr_acc ? '0 : acc_sel) : a;
        y = is_acc ? a : b;
    end

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .x       (x),
        .y       (y),
        .sub     (op[0]),
        .sat     (is_acc && (SATURATE != 0)),
        .raw     (raw),
        .clamped (clamped),
        .ovf     (core_ovf)
    );

    // Next result: bad channel yields 0; saturating ACC reports the clamped value.
    always_comb begin
        res_nxt = raw;
        ovf_nxt = core_ovf;
        if (is_acc && !ch_ok) begin
            res_nxt = '0;
            ovf_nxt = 1'b0;
        end else if (is_acc && (SATURATE != 0)) begin
            res_nxt = {1'b0, clamped};
        end
    end

    // Accumulators: written by accepted ACC beats, otherwise cleared by clr_acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (accept && is_acc && ch_ok && ch == CHW'(i))
                    acc[i] <= clamped;
                else if (clr_acc)
                    acc[i] <= '0;
            end
        end
    end

    // Output register: load on accept, drop valid once consumed with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= res_nxt;
            zero      <= (res_nxt[WIDTH-1:0] == '0);
            ovf       <= ovf_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_acc_multi.sv
// Scoreboard bench: wrapping and saturating instances share one stimulus stream.
module tb_addsub_acc_multi;
    import addsub_acc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       clr_acc = 1'b0;
    logic       out_ready = 1'b1;
    logic [1:0] op = 2'b00;
    logic [1:0] ch = 2'b00;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       rdy0, rdy1, ov0, ov1, z0, z1, f0, f1;
    logic [4:0] res0, res1;

    int tests = 0;
    int fails = 0;
    int macc [2][3];
    logic [6:0] q0 [$];
    logic [6:0] q1 [$];

    always #5 clk = ~clk;

    addsub_acc_multi #(.WIDTH(4), .NCH(3), .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .op(op), .ch(ch), .a(a), .b(b), .clr_acc(clr_acc),
        .out_valid(ov0), .out_ready(out_ready), .result(res0), .zero(z0), .ovf(f0)
    );

    addsub_acc_multi #(.WIDTH(4), .NCH(3), .SATURATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .op(op), .ch(ch), .a(a), .b(b), .clr_acc(clr_acc),
        .out_valid(ov1), .out_ready(out_ready), .result(res1), .zero(z1), .ovf(f1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model in plain integer arithmetic; returns {result, zero, ovf}.
    task automatic apply(input int s, input logic [1:0] o, input logic [1:0] c,
                         input logic [3:0] av, input logic [3:0] bv, input logic clr,
                         output logic [6:0] e);
        int v, r, ov;
        if (clr)
            for (int i = 0; i < 3; i++) macc[s][i] = 0;
        if (o == OP_ADD || o == OP_SUB) begin
            v  = (o == OP_ADD) ? int'(av) + int'(bv) : int'(av) - int'(bv);
            r  = (v + 32) % 32;
            ov = r / 16;
        end else if (c >= 3) begin
            r  = 0;
            ov = 0;
        end else begin
            v = (o == OP_ACC_ADD) ? macc[s][c] + int'(av) : macc[s][c] - int'(av);
            if (s == 0) begin
                r  = (v + 32) % 32;
                ov = r / 16;
                macc[s][c] = r % 16;
            end else if (v > 15) begin
                r = 15; ov = 1; macc[s][c] = 15;
            end else if (v < 0) begin
                r = 0; ov = 1; macc[s][c] = 0;
            end else begin
                r = v; ov = 0; macc[s][c] = v;
            end
        end
        e = {r[4:0], (r % 16) == 0, ov[0]};
    endtask

    // Drive one beat from a negedge; model and queue it at the cycle it is accepted.
    task automatic send(input logic [1:0] o, input logic [1:0] c, input logic [3:0] av,
                        input logic [3:0] bv, input logic clr);
        logic [6:0] e;
        int n;
        n = 0;
        op = o; ch = c; a = av; b = bv; clr_acc = clr; in_valid = 1'b1;
        #1;
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            out_ready = (n >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        if (!rdy0) begin
            tests++;
            fails++;
            $display("FAIL send_timeout got=in_ready_low exp=accept_within_50");
        end else begin
            apply(0, o, c, av, bv, clr, e);
            q0.push_back(e);
            apply(1, o, c, av, bv, clr, e);
            q1.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        clr_acc  = 1'b0;
    endtask

    // Monitor: compare each consumed result against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_ready) begin
            if (ov0) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL wrap_unexpected got=%0h exp=none", {res0, z0, f0});
                end else chk("wrap_out", {res0, z0, f0}, q0.pop_front());
            end
            if (ov1) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sat_unexpected got=%0h exp=none", {res1, z1, f1});
                end else chk("sat_out", {res1, z1, f1}, q1.pop_front());
            end
        end
    end

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 3; i++) macc[s][i] = 0;

        // Reset state
        #1;
        chk("rst_valid", {ov0, ov1}, 2'b00);
        chk("rst_result", {res0, res1}, 10'h0);
        chk("rst_flags", {z0, f0, z1, f1}, 4'h0);
        chk("rst_in_ready", {rdy0, rdy1}, 2'b11);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain add/sub
        send(OP_ADD, 0, 4'hF, 4'h1, 0);
        send(OP_SUB, 0, 4'h3, 4'h5, 0);
        send(OP_SUB, 0, 4'h5, 4'h5, 0);

        // Channel independence (wrap) / clamp-up (sat)
        send(OP_ACC_ADD, 0, 4'h0, 4'h0, 1);
        send(OP_ACC_ADD, 0, 4'h6, 4'h0, 0);
        send(OP_ACC_ADD, 0, 4'h7, 4'h0, 0);
        send(OP_ACC_ADD, 1, 4'h1, 4'h0, 0);
        send(OP_ACC_ADD, 0, 4'h4, 4'h0, 0);
        send(OP_ACC_ADD, 0, 4'h0, 4'h0, 0);

        // Saturation edges
        send(OP_ACC_ADD, 0, 4'hD, 4'h0, 1);
        send(OP_ACC_ADD, 0, 4'h5, 4'h0, 0);
        send(OP_ACC_ADD, 0, 4'h2, 4'h0, 1);
        send(OP_ACC_SUB, 0, 4'hF, 4'h0, 0);

        // Clear alongside an accepted beat, then read other channels; bad channel
        send(OP_ACC_ADD, 1, 4'h4, 4'h0, 1);
        send(OP_ACC_ADD, 0, 4'h0, 4'h0, 0);
        send(OP_ACC_ADD, 2, 4'h0, 4'h0, 0);
        send(OP_ACC_ADD, 3, 4'h7, 4'h0, 0);
        send(OP_ACC_ADD, 1, 4'h0, 4'h0, 0);

        // Backpressure: held result, no acceptance, accumulator untouched
        @(negedge clk);
        out_ready = 1'b0;
        send(OP_ACC_ADD, 0, 4'h2, 4'h0, 1);
        op = OP_ACC_ADD; ch = 0; a = 4'h3; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("stall_in_ready", rdy0, 1'b0);
            chk("stall_valid", {ov0, ov1}, 2'b11);
            chk("stall_hold", {res0, z0, f0}, q0[0]);
        end
        out_ready = 1'b1;
        send(OP_ACC_ADD, 0, 4'h3, 4'h0, 0);

        // Asynchronous reset while a result is held
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        send(OP_ACC_ADD, 0, 4'h9, 4'h0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {ov0, ov1}, 2'b00);
        chk("async_rst_result", {res0, res1}, 10'h0);
        chk("async_rst_in_ready", rdy0, 1'b1);
        q0.delete();
        q1.delete();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 3; i++) macc[s][i] = 0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(OP_ACC_ADD, 0, 4'h0, 4'h0, 0);

        // Randomized traffic with random backpressure
        repeat (300) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0));
        end

        // Drain
        out_ready = 1'b1;
        for (int n = 0; n < 20 && (q0.size() + q1.size()) != 0; n++) @(negedge clk);
        @(negedge clk);
        chk("drain_empty", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/addsub_acc_multi.md
Name: addsub_acc_multi

Overview:
- Parametrised, registered add/subtract/accumulate unit. Successor to the single-width combinational adder/subtractor blocks.
- Adds configurable operand width, multiple independent accumulator channels, and an optional saturating mode.
- Uses valid/ready handshakes on input and output.
- Sits between an operand source and a result consumer in datapath test designs; one result per accepted operand beat.

Parameters:
- WIDTH, 4: operand and accumulator width in bits (>=2).
- NCH, 2: number of independent accumulator channels (>=1).
- SATURATE, 0: 0 = accumulators wrap modulo 2^WIDTH; 1 = accumulators clamp to [0, 2^WIDTH-1].

Ports:
- clk  in  1  single clock; all state rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- op  in  2  00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB.
- ch  in  max(1,$clog2(NCH))  accumulator channel for ACC ops; ignored for ADD/SUB.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ADD/SUB only).
- clr_acc  in  1  synchronous strobe; clears all channel accumulators.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH+1  MSB = carry/borrow, low WIDTH bits = value.
- zero  out  1  result[WIDTH-1:0] == 0.
- ovf  out  1  unsigned carry (add) / borrow (sub), or clamp occurred when SATURATE=1.

Behaviour:
- Reset (rst_n low, async):
  - out_valid, result, zero, ovf = 0.
  - All NCH accumulators = 0.
  - Takes effect immediately, discarding any held result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational); in_ready is 1 while in reset.
  - A beat is accepted when in_valid && in_ready.
  - Latency is 1 cycle: the accepted beat's result is registered and out_valid is set on the next edge.
  - Full throughput when out_ready is held high.
  - While out_valid && !out_ready: result, zero and ovf are held stable, and no beat is accepted.
  - out_valid clears when the result is consumed (out_valid && out_ready) and no new beat is accepted in the same cycle.
- ADD: result = {1'b0,a} + {1'b0,b}; ovf = result[WIDTH].
- SUB: result = {1'b0,a} - {1'b0,b}, two's complement over WIDTH+1 bits; ovf = result[WIDTH] (borrow).
- ACC_ADD / ACC_SUB:
  - Computation: s = acc[ch] +/- a over WIDTH+1 bits.
  - SATURATE=0: acc[ch] <= s[WIDTH-1:0]; result = s; ovf = s[WIDTH].
  - SATURATE=1, on carry (add) or borrow (sub): acc[ch] clamps to all-ones (add) or 0 (sub); result = {1'b0, clamped}; ovf = 1.
- Accumulator update rules:
  - Accumulators update only on an accepted ACC beat, never on ADD/SUB or a stalled beat.
  - An ACC beat with ch >= NCH is accepted: it produces result 0 and ovf 0, and updates no accumulator.
- clr_acc:
  - Acts whether or not a beat is accepted.
  - Same cycle as an accepted ACC beat: the clear takes priority and the op is applied to 0, e.g. ACC_ADD gives acc[ch] = a.
  - Does not alter the result register or out_valid.
- zero and ovf are registered alongside result and always describe the held result.

Decomposition:
- Package addsub_acc_pkg:
  - localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_ACC_ADD=2'b10, OP_ACC_SUB=2'b11.
  - Function computing channel-select width from NCH.
- Sub-module addsub_core (combinational):
  - Inputs: WIDTH-bit x, y, sub, sat.
  - Outputs: WIDTH+1 raw sum, clamped WIDTH-bit value, ovf flag.
  - Instantiated once and shared by all ops via operand muxing (x = a or acc[ch]).
- Accumulator array, handshake and output register live in the top module.

Test Plan:
- WIDTH=4, out_ready=1: ADD a=4'hF, b=4'h1 -> next cycle out_valid=1, result=5'h10, ovf=1, zero=1.
- SUB a=4'h3, b=4'h5 -> result=5'h1E, ovf=1, zero=0; SUB a=4'h5, b=4'h5 -> result=5'h00, zero=1, ovf=0.
- SATURATE=0, channel independence:
  - Beats: ACC_ADD ch0 a=6; ACC_ADD ch0 a=7; ACC_ADD ch1 a=1; ACC_ADD ch0 a=4.
  - Required results: 5'h06, 5'h0D, 5'h01, 5'h11 (ovf=1), and acc0 = 4'h1.
- SATURATE=1:
  - acc0=13, ACC_ADD a=5 -> result=5'h0F, ovf=1, acc0=15.
  - acc0=2, ACC_SUB a=4'hF -> result=0, ovf=1, zero=1.
- Backpressure and clear:
  - out_ready=0 with out_valid=1: in_ready=0, result stable over 5 cycles, acc unchanged despite in_valid=1.
  - clr_acc with an accepted ACC_ADD ch1 a=4 -> result=5'h04, and all other channels read 0 on later ACC_ADD a=0.
- Reset mid-operation: rst_n low asynchronously while out_valid=1 with acc0=9 -> out_valid=0 immediately, and after release ACC_ADD ch0 a=0 -> result=0.
